hslp_seq_ctrl: RTL and testbench
================================

// Module: hslp_seq_ctrl
// PURPOSE
//   Sequencer that time-shares ONE external 4x4 approximate sub-multiplier port to form an 8x8 product.
//   The four nibble partial products are issued over successive cycles: LL, LH, HL, HH.
//   Each returned 8-bit product is accumulated at its weight (<<0, <<4, <<4, <<8).
//   Sits between the 8x8 operand source and a shared ap1/ap2 core pair, replacing four parallel instances.
// PARAMETERS
//   CFG_RST    4'b1000  reset value of the core-select register; bit0=LL, bit1=LH, bit2=HL, bit3=HH;
//                       1=ap1 core, 0=ap2 core
//   ZERO_SKIP  1        1: skip any step whose a-nibble or b-nibble is 0 (contributes 0)
//   SAT_EN     1        1: saturate result to 16'hFFFF on overflow; 0: keep low 16 bits (wrap)
// PORTS
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operand request
//   in_ready   out  1   controller can accept an operand pair
//   a          in   8   multiplicand
//   b          in   8   multiplier
//   cfg_we     in   1   write cfg_sel into core-select register
//   cfg_sel    in   4   core-select value (bit map as CFG_RST)
//   pp_a       out  4   nibble operand A to the shared core
//   pp_b       out  4   nibble operand B to the shared core
//   pp_sel     out  1   1=ap1 core, 0=ap2 core for the current step
//   pp_prod    in   8   combinational product returned by the selected core (same cycle)
//   out_valid  out  1   result available
//   out_ready  in   1   consumer accepts result
//   prod       out  16  8x8 approximate product
//   busy       out  1   high in any state other than IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     state=IDLE; in_ready=1; out_valid=0; prod=0; pp_a=pp_b=0; pp_sel=0; busy=0;
//     accumulator=0; cfg register=CFG_RST.
//     Reset asserted mid-operation aborts the operation; no partial result is emitted.
//   States: IDLE -> LL -> LH -> HL -> HH -> DONE -> IDLE.
//   IDLE:
//     - in_ready=1.
//     - in_valid&in_ready captures a, b and the current cfg register into shadow regs.
//     - Clears the 17-bit accumulator and moves to the first non-skipped step.
//   Step states:
//     - Drive pp_a/pp_b with the nibbles (LL: a[3:0],b[3:0]; LH: a[3:0],b[7:4];
//       HL: a[7:4],b[3:0]; HH: a[7:4],b[7:4]) and drive pp_sel from the shadow cfg bit.
//     - Sample pp_prod on the clock edge that ends the state and add it at its weight into the 17-bit accumulator.
//     - Outside step states, pp_a=pp_b=0 and pp_sel=0.
//   Zero skip (ZERO_SKIP=1): a step whose a-nibble or b-nibble is 0 is never entered. The next state is the next non-skipped step, or DONE.
//     - If all four steps are skipped, IDLE goes directly to DONE with prod=0.
//   DONE:
//     - prod = SAT_EN ? (acc[16] ? 16'hFFFF : acc[15:0]) : acc[15:0]; out_valid=1.
//     - prod and out_valid stay stable until out_ready=1, then return to IDLE.
//     - in_ready=0 in DONE; there is no overlap of operations.
//   Latency: accept edge to out_valid = (non-skipped steps)+1 cycles; 5 cycles with no skips.
//   Throughput: with out_ready tied high, 1 result per 6 cycles.
//   cfg_we: may be written in any state and updates the register next edge.
//     - An in-flight operation always uses its shadow copy.
//     - cfg_we in the same cycle as an accept: the OLD value is captured.
//   The accumulator is 17 bits, so no intermediate wrap can occur (max 255*289 = 73695).
// TESTING
//   T1: core model exact, no skips. a=8'hFF, b=8'hFF, accept at t0
//       -> pp steps LL,LH,HL,HH at t1..t4; out_valid at t5; prod=16'hFE01.
//   T2: ZERO_SKIP=1. a=8'h0F, b=8'h0F
//       -> only LL is issued (pp_a=pp_b=4'hF); out_valid 2 cycles after accept; prod=16'h00E1.
//   T3: core model returns 8'hFF for every step. a=b=8'h11
//       -> SAT_EN=1 gives prod=16'hFFFF; SAT_EN=0 gives prod=16'h1FDF.
//   T4: default cfg. Check pp_sel=0,0,0,1 across LL,LH,HL,HH.
//       Then cfg_we with cfg_sel=4'b0101 mid-operation
//       -> the current operation is unchanged; the next operation gives pp_sel=1,0,1,0.
//   T5: out_ready held 0 for 3 cycles in DONE
//       -> prod and out_valid stable, in_ready=0, in_valid ignored; result pops on out_ready=1.
//   T6: rst_n pulsed low during HL
//       -> out_valid never asserts, busy=0 and in_ready=1 immediately, cfg=CFG_RST;
//          the next operation is correct.

Source files
------------

// File: rtl/hslp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// hslp_seq_ctrl
//   Forms an 8x8 approximate product by time-sharing one external 4x4
//   sub-multiplier port. The four nibble partial products are issued on
//   successive cycles in the order LL, LH, HL, HH. Each 8-bit result returned
//   by the core is added into a 17-bit accumulator at its weight
//   (<<0, <<4, <<4, <<8).
//
// Parameters
//   CFG_RST    reset value of the core-select register
//              (bit0=LL, bit1=LH, bit2=HL, bit3=HH; 1=ap1 core, 0=ap2 core)
//   ZERO_SKIP  1: steps whose a-nibble or b-nibble is zero are never issued
//   SAT_EN     1: saturate to 16'hFFFF on overflow, 0: keep the low 16 bits
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake, a/b operands
//   cfg_we/cfg_sel      core-select register write
//   pp_a/pp_b/pp_sel    nibble operands and core select to the shared core
//   pp_prod             combinational product from the selected core
//   out_valid/out_ready result handshake, prod is the 16-bit result
//   busy                high whenever the sequencer is not idle
//   dbg_state           current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; once out_valid rises, prod and
// out_valid hold until out_ready is seen high, so operations never overlap.
// -----------------------------------------------------------------------------
module hslp_seq_ctrl #(
  parameter logic [3:0] CFG_RST   = 4'b1000,
  parameter bit         ZERO_SKIP = 1'b1,
  parameter bit         SAT_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_sel,
  output logic [3:0]  pp_a,
  output logic [3:0]  pp_b,
  output logic        pp_sel,
  input  logic [7:0]  pp_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] prod,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LL   = 3'd1,
    ST_LH   = 3'd2,
    ST_HL   = 3'd3,
    ST_HH   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t      r_state;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [3:0]  r_cfg;
  logic [3:0]  r_cfg_sh;
  logic [16:0] r_acc;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [15:0] r_prod;
  logic [3:0]  r_pp_a;
  logic [3:0]  r_pp_b;
  logic        r_pp_sel;
  logic        r_busy;

  state_t      w_next;
  logic        w_accept;
  logic        w_in_step;
  logic        w_next_step;
  logic [1:0]  w_idx;
  logic [1:0]  w_nidx;
  logic [7:0]  w_src_a;
  logic [7:0]  w_src_b;
  logic [3:0]  w_src_cfg;
  logic [16:0] w_weighted;
  logic [16:0] w_acc_next;
  logic [15:0] w_result;

  // Step index: 0=LL, 1=LH, 2=HL, 3=HH. Bit 1 picks the a-nibble,
  // bit 0 picks the b-nibble.
  function automatic logic [3:0] nib_a(input logic [7:0] op, input logic [1:0] idx);
    return idx[1] ? op[7:4] : op[3:0];
  endfunction

  function automatic logic [3:0] nib_b(input logic [7:0] op, input logic [1:0] idx);
    return idx[0] ? op[7:4] : op[3:0];
  endfunction

  function automatic logic step_live(input logic [7:0] op_a, input logic [7:0] op_b,
                                     input logic [1:0] idx);
    return !ZERO_SKIP || ((nib_a(op_a, idx) != 4'd0) && (nib_b(op_b, idx) != 4'd0));
  endfunction

  // First live step with index >= from, or DONE when none remains.
  function automatic state_t pick_next(input logic [7:0] op_a, input logic [7:0] op_b,
                                       input logic [2:0] from);
    state_t nxt;
    logic   found;
    nxt   = ST_DONE;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && (i >= int'(from)) && step_live(op_a, op_b, 2'(i))) begin
        nxt   = state_t'(3'(i + 1));
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

  assign w_accept  = in_valid && r_in_ready && (r_state == ST_IDLE);
  assign w_in_step = (r_state == ST_LL) || (r_state == ST_LH) ||
                     (r_state == ST_HL) || (r_state == ST_HH);
  assign w_idx     = 2'(r_state - 3'd1);

  // Operands for the step being entered: live inputs on the accept edge,
  // shadow copies afterwards. The live cfg register (not cfg_sel) is used on
  // accept so a simultaneous cfg write does not leak into this operation.
  assign w_src_a   = (r_state == ST_IDLE) ? a     : r_a;
  assign w_src_b   = (r_state == ST_IDLE) ? b     : r_b;
  assign w_src_cfg = (r_state == ST_IDLE) ? r_cfg : r_cfg_sh;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = pick_next(a, b, 3'd0);
      ST_LL, ST_LH, ST_HL, ST_HH: w_next = pick_next(r_a, r_b, {1'b0, w_idx} + 3'd1);
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_next_step = (w_next == ST_LL) || (w_next == ST_LH) ||
                       (w_next == ST_HL) || (w_next == ST_HH);
  assign w_nidx      = 2'(w_next - 3'd1);

  always_comb begin
    w_weighted = 17'd0;
    case (w_idx)
      2'd0:       w_weighted = {9'd0, pp_prod};
      2'd1, 2'd2: w_weighted = {5'd0, pp_prod, 4'd0};
      default:    w_weighted = {1'b0, pp_prod, 8'd0};
    endcase
  end

  assign w_acc_next = r_acc + w_weighted;
  assign w_result   = (SAT_EN && w_acc_next[16]) ? 16'hFFFF : w_acc_next[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= 8'd0;
      r_b         <= 8'd0;
      r_cfg       <= CFG_RST;
      r_cfg_sh    <= CFG_RST;
      r_acc       <= 17'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_prod      <= 16'd0;
      r_pp_a      <= 4'd0;
      r_pp_b      <= 4'd0;
      r_pp_sel    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (cfg_we) r_cfg <= cfg_sel;

      r_state    <= w_next;
      r_busy     <= (w_next != ST_IDLE);
      r_in_ready <= (w_next == ST_IDLE);

      // Core-port outputs are registered for the state being entered.
      if (w_next_step) begin
        r_pp_a   <= nib_a(w_src_a, w_nidx);
        r_pp_b   <= nib_b(w_src_b, w_nidx);
        r_pp_sel <= w_src_cfg[w_nidx];
      end else begin
        r_pp_a   <= 4'd0;
        r_pp_b   <= 4'd0;
        r_pp_sel <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_cfg_sh <= r_cfg;
            r_acc    <= 17'd0;
            // Every step skipped: result is zero without touching the core.
            if (w_next == ST_DONE) begin
              r_prod      <= 16'd0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_LL, ST_LH, ST_HL, ST_HH: begin
          r_acc <= w_acc_next;
          if (w_next == ST_DONE) begin
            r_prod      <= w_result;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  // w_in_step is kept for readability of the datapath; the accumulator add
  // above is only committed in step states.
  logic w_unused;
  assign w_unused = w_in_step;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign prod      = r_prod;
  assign pp_a      = r_pp_a;
  assign pp_b      = r_pp_b;
  assign pp_sel    = r_pp_sel;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hslp_seq_ctrl.sv
// Bench for hslp_seq_ctrl. Two instances: dut0 with defaults (zero skip and
// saturation on) and dut1 with zero skip and saturation off. The reference
// model computes the list of issued steps and the final product directly
// from the nibble arithmetic.
module tb_hslp_seq_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [7:0]  a, b;
  logic [3:0]  cfg_sel;
  logic        in_valid  [2];
  logic        cfg_we    [2];
  logic        out_ready [2];
  logic        in_ready  [2];
  logic        pp_sel    [2];
  logic        out_valid [2];
  logic        busy      [2];
  logic [3:0]  pp_a      [2];
  logic [3:0]  pp_b      [2];
  logic [7:0]  pp_prod   [2];
  logic [15:0] prod      [2];
  logic [2:0]  dbg_state [2];

  int         core_mode;
  logic [3:0] mcfg [2];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];

  // Core model: 0 exact, 1 always 8'hFF, 2 ap2 drops two LSBs.
  function automatic logic [7:0] core(input int mode, input logic [3:0] x,
                                      input logic [3:0] y, input logic s);
    logic [7:0] p;
    p = {4'd0, x} * {4'd0, y};
    case (mode)
      1:       return 8'hFF;
      2:       return s ? p : (p & 8'hFC);
      default: return p;
    endcase
  endfunction

  always_comb begin
    for (int k = 0; k < 2; k++) pp_prod[k] = core(core_mode, pp_a[k], pp_b[k], pp_sel[k]);
  end

  hslp_seq_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .cfg_we(cfg_we[0]), .cfg_sel(cfg_sel),
    .pp_a(pp_a[0]), .pp_b(pp_b[0]), .pp_sel(pp_sel[0]), .pp_prod(pp_prod[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .prod(prod[0]),
    .busy(busy[0]), .dbg_state(dbg_state[0])
  );

  hslp_seq_ctrl #(.CFG_RST(4'b1000), .ZERO_SKIP(1'b0), .SAT_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a), .b(b), .cfg_we(cfg_we[1]), .cfg_sel(cfg_sel),
    .pp_a(pp_a[1]), .pp_b(pp_b[1]), .pp_sel(pp_sel[1]), .pp_prod(pp_prod[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .prod(prod[1]),
    .busy(busy[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver: one full operation ----------------
  task automatic do_op(input int k, input logic [7:0] op_a, input logic [7:0] op_b,
                       input int hold, input bit we_accept, input bit we_mid,
                       input logic [3:0] new_cfg, output logic [15:0] got);
    int unsigned sum;
    int          nsteps;
    int          cyc;
    int          sh;
    bit          wrote;
    logic [3:0]  an, bn, cfg_use;
    logic [15:0] expp;

    cyc = 0;
    while (in_ready[k] !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("in_ready_before_op", 32'(in_ready[k]), 32'd1);

    // Reference: which steps are issued and what they add up to.
    cfg_use = mcfg[k];
    exp_q.delete();
    sum = 0;
    nsteps = 0;
    for (int i = 0; i < 4; i++) begin
      an = (i >= 2) ? op_a[7:4] : op_a[3:0];
      bn = (i % 2 == 1) ? op_b[7:4] : op_b[3:0];
      if (k == 0 && (an == 4'd0 || bn == 4'd0)) continue;
      exp_q.push_back({an, bn, cfg_use[i]});
      nsteps++;
      sh = (i == 0) ? 0 : ((i == 3) ? 8 : 4);
      sum += 32'(core(core_mode, an, bn, cfg_use[i])) << sh;
    end
    if (k == 0) expp = (sum > 32'd65535) ? 16'hFFFF : 16'(sum);
    else        expp = 16'(sum);

    a = op_a;
    b = op_b;
    in_valid[k] = 1'b1;
    if (we_accept) begin
      cfg_we[k] = 1'b1;
      cfg_sel   = new_cfg;
    end
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    cfg_we[k]   = 1'b0;
    if (we_accept) mcfg[k] = new_cfg;

    wrote = 1'b0;
    cyc = 1;
    while (out_valid[k] !== 1'b1 && cyc <= 6) begin
      if (exp_q.size() > 0) chk("pp_step", 32'({pp_a[k], pp_b[k], pp_sel[k]}), 32'(exp_q.pop_front()));
      else                  chk("unexpected_extra_step", 32'(out_valid[k]), 32'd1);
      chk("busy_in_step", 32'(busy[k]), 32'd1);
      chk("in_ready_in_step", 32'(in_ready[k]), 32'd0);
      if (we_mid && cyc == 1) begin
        cfg_we[k] = 1'b1;
        cfg_sel   = new_cfg;
        wrote     = 1'b1;
      end else begin
        cfg_we[k] = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    cfg_we[k] = 1'b0;
    if (wrote) mcfg[k] = new_cfg;

    chk("latency", 32'(cyc), 32'(nsteps + 1));
    chk("steps_left", 32'(exp_q.size()), 32'd0);
    chk("prod", 32'(prod[k]), 32'(expp));
    chk("pp_zero_in_done", 32'({pp_a[k], pp_b[k], pp_sel[k]}), 32'd0);
    chk("in_ready_in_done", 32'(in_ready[k]), 32'd0);
    got = prod[k];

    // Consumer stalls; new requests during DONE must be ignored.
    for (int h = 0; h < hold; h++) begin
      in_valid[k] = 1'b1;
      a = ~op_a;
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid[k]), 32'd1);
      chk("hold_prod", 32'(prod[k]), 32'(expp));
      chk("hold_in_ready", 32'(in_ready[k]), 32'd0);
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    chk("pop_out_valid", 32'(out_valid[k]), 32'd0);
    chk("pop_in_ready", 32'(in_ready[k]), 32'd1);
    chk("pop_busy", 32'(busy[k]), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] got;
    logic [7:0]  ra, rb;
    logic [3:0]  rc;
    int          rk;

    a = 8'd0; b = 8'd0; cfg_sel = 4'd0; core_mode = 0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; cfg_we[k] = 1'b0; out_ready[k] = 1'b0;
      mcfg[k] = 4'b1000;
    end

    // Reset values
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", 32'(in_ready[k]), 32'd1);
      chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
      chk("rst_prod", 32'(prod[k]), 32'd0);
      chk("rst_busy", 32'(busy[k]), 32'd0);
      chk("rst_pp", 32'({pp_a[k], pp_b[k], pp_sel[k]}), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: exact core, no skips
    do_op(0, 8'hFF, 8'hFF, 0, 1'b0, 1'b0, 4'd0, got);
    chk("T1_prod_const", 32'(got), 32'h0000FE01);

    // T2: only LL live
    do_op(0, 8'h0F, 8'h0F, 0, 1'b0, 1'b0, 4'd0, got);
    chk("T2_prod_const", 32'(got), 32'h000000E1);
    // every step skipped
    do_op(0, 8'h00, 8'h37, 0, 1'b0, 1'b0, 4'd0, got);
    chk("all_skip_prod", 32'(got), 32'd0);
    // no skipping in dut1 even with zero nibbles
    do_op(1, 8'h0F, 8'h0F, 0, 1'b0, 1'b0, 4'd0, got);
    chk("noskip_prod", 32'(got), 32'h000000E1);

    // T3: core returns FF every step
    core_mode = 1;
    do_op(0, 8'h11, 8'h11, 0, 1'b0, 1'b0, 4'd0, got);
    chk("T3_sat_const", 32'(got), 32'h0000FFFF);
    do_op(1, 8'h11, 8'h11, 0, 1'b0, 1'b0, 4'd0, got);
    chk("T3_wrap_const", 32'(got), 32'h00001FDF);
    core_mode = 0;

    // T4: default cfg, then cfg write mid-operation
    do_op(0, 8'h23, 8'h45, 0, 1'b0, 1'b1, 4'b0101, got);
    do_op(0, 8'h23, 8'h45, 0, 1'b0, 1'b0, 4'd0, got);
    // cfg write on the accept edge: old value used, new value next time
    core_mode = 2;
    do_op(0, 8'h99, 8'h99, 0, 1'b1, 1'b0, 4'b1111, got);
    do_op(0, 8'h99, 8'h99, 0, 1'b0, 1'b0, 4'd0, got);
    core_mode = 0;

    // T5: consumer stalls 3 cycles
    do_op(0, 8'hA7, 8'h3C, 3, 1'b0, 1'b0, 4'd0, got);

    // T6: reset during HL
    a = 8'h55; b = 8'h55; in_valid[0] = 1'b1;
    @(posedge clk); #1; in_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("T6_in_HL", 32'({pp_a[0], pp_b[0]}), 32'h55);
    rst_n = 1'b0;
    #1;
    chk("T6_busy", 32'(busy[0]), 32'd0);
    chk("T6_in_ready", 32'(in_ready[0]), 32'd1);
    chk("T6_out_valid", 32'(out_valid[0]), 32'd0);
    chk("T6_pp", 32'({pp_a[0], pp_b[0], pp_sel[0]}), 32'd0);
    #7;
    rst_n = 1'b1;
    mcfg[0] = 4'b1000;
    mcfg[1] = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("T6_no_result", 32'(out_valid[0]), 32'd0);
    end
    do_op(0, 8'h5A, 8'hC3, 0, 1'b0, 1'b0, 4'd0, got);

    // Randomized operations with the approximate core model
    core_mode = 2;
    for (int n = 0; n < 24; n++) begin
      rk = int'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ra[3:0] = 4'd0;
      if ($urandom_range(0, 3) == 0) rb[7:4] = 4'd0;
      rc = 4'($urandom);
      do_op(rk, ra, rb, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), rc, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
